tlb_op_seq: RTL and testbench
=============================

TLB_OP_SEQ -- requirements
Module: tlb_op_seq

Interface
REQ-001 SHALL have parameter TLBNUM, default 32, meaning the number of TLB entries; the index width IDXW = log2(TLBNUM) = 5.
REQ-002 SHALL have port clk  input  1  the single clock; all state updates on posedge clk.
REQ-003 SHALL have port reset  input  1  asynchronous, active-low reset.
REQ-004 SHALL have ports req_valid  input  1 and req_ready  output  1: the request handshake from WB; a request is accepted when both are 1.
REQ-005 SHALL have port req_op  input  4  one-hot request code: [0] invtlb, [1] tlbwr, [2] tlbrd, [3] tlbfill.
REQ-006 SHALL have ports inv_op  input  5, inv_asid  input  10 and inv_vpn  input  19: the invtlb operands.
REQ-007 SHALL have port csr_tlbidx  input  IDXW  the TLBIDX.Index field, used by tlbwr and tlbrd.
REQ-008 SHALL have ports tlb_we  output  1 and tlb_w_index  output  IDXW: the write strobe and write index of the TLB write port (entry data comes from the CSRs).
REQ-009 SHALL have ports tlb_re  output  1 and tlb_r_index  output  IDXW: the TLB read port; data returns one cycle later.
REQ-010 SHALL have ports r_e  input  1, r_g  input  1, r_asid  input  10 and r_vppn  input  19: the read-port data.
REQ-011 SHALL have ports tlb_clr  output  1 and tlb_clr_index  output  IDXW: the strobe that clears an entry's E bit.
REQ-012 SHALL have port rd_capture  output  1, which tells the CSR unit to latch the read data (tlbrd).
REQ-013 SHALL have port done  output  1, a one-cycle pulse when the accepted operation completes.
REQ-014 SHALL have port busy  output  1, which is 1 in every state except IDLE.

Function
REQ-015 SHALL have these states: IDLE, WR, RD, RD_CAP, INV_SCAN, INV_DRAIN and DONE.
REQ-016 SHALL drive req_ready = 1 only in IDLE; a request arriving in any other state is held off and no operand is sampled.
REQ-017 SHALL register req_op and all operands on acceptance; input changes after acceptance have no effect.
REQ-018 SHALL, for tlbwr: IDLE->WR; in WR, tlb_we=1 and tlb_w_index=csr_tlbidx (sampled at acceptance); WR->DONE.
REQ-019 SHALL, for tlbfill: same as tlbwr, with the index taken from fill_cnt sampled at acceptance.
REQ-020 SHALL implement fill_cnt as an IDXW-bit free-running counter that increments every cycle and wraps from TLBNUM-1 to 0.
REQ-021 SHALL, for tlbrd: RD issues tlb_re with the sampled index; RD_CAP asserts rd_capture=1; RD_CAP->DONE.
REQ-022 SHALL, for invtlb, run a two-stage scan:
  - INV_SCAN issues tlb_re for index i = 0..TLBNUM-1, one per cycle.
  - Entry i is compared one cycle after its read; the last compare happens in INV_DRAIN.
  - A matching entry gets tlb_clr=1 with tlb_clr_index=i in that compare cycle.
REQ-023 SHALL define a match as r_e=1 and the inv_op rule being true:
  - 0 or 1: all entries.
  - 2: g=1.
  - 3: g=0.
  - 4: g=0 and asid equal.
  - 5: g=0, asid equal and vppn equal.
  - 6: (g=1 or asid equal) and vppn equal.
REQ-024 SHALL treat inv_op values 7..31 as a no-op: IDLE->DONE directly, with no tlb_re and no tlb_clr.
REQ-025 SHALL make invtlb latency (acceptance to done) TLBNUM+2 cycles, and tlbwr/tlbfill/tlbrd latency 2/2/3 cycles respectively.
REQ-026 SHALL pulse done for exactly one cycle in DONE, then return to IDLE; a new request is acceptable in the cycle after done.
REQ-027 SHALL treat a req_op that is zero or not one-hot on acceptance as a no-op that completes via DONE.
REQ-028 SHALL never assert tlb_we, tlb_re and tlb_clr outside their stated states.
REQ-029 SHALL never assert tlb_we and tlb_clr in the same cycle.
REQ-030 SHALL not be aborted by WB flushes once an operation is accepted; the operation always completes.

Reset
REQ-031 SHALL, while reset=0 (asynchronously), force: state=IDLE, fill_cnt=0, scan index=0, all registered operands=0.
REQ-032 SHALL, during reset, drive the outputs as: req_ready=0, busy=0, done=0, tlb_we=0, tlb_re=0, tlb_clr=0, rd_capture=0, all index outputs=0.
REQ-033 SHALL drive req_ready=1 from the first clock edge after reset deasserts.
REQ-034 SHALL, if reset asserts mid-operation, abandon the operation with no done pulse and issue no further port strobes.

Structure
REQ-035 SHALL place in the shared defines package: the TLBNUM/IDXW constants, the state encoding, the req_op bit positions and the inv_op codes 0..6.
REQ-036 SHALL have one sub-module, tlb_inv_match: a purely combinational REQ-023 comparator.

Verification
REQ-037 SHALL cover tlbwr with csr_tlbidx=5: tlb_we=1 and tlb_w_index=5 one cycle after acceptance, done the following cycle.
REQ-038 SHALL cover invtlb op=5, asid=0x3, vpn=0x1234, with entries 7 (g=0, asid 3, vppn 0x1234) and 9 (g=1, same fields) valid: only entry 7 is cleared (tlb_clr_index=7); done 34 cycles after acceptance.
REQ-039 SHALL cover invtlb op=0 with all 32 entries valid: 32 consecutive tlb_clr pulses with indices 0..31.
REQ-040 SHALL cover tlbfill issued 3 cycles after reset release: tlb_w_index=3.
REQ-041 SHALL cover tlbfill issued 35 cycles after reset release: tlb_w_index=3, confirming fill_cnt wrap.
REQ-042 SHALL cover req_valid held during an invtlb scan: req_ready=0 throughout the scan; the second request is accepted in the cycle after done.
REQ-043 SHALL cover reset asserted at scan index 10: all strobes go to 0 immediately, with no done pulse.
REQ-044 SHALL cover inv_op=9: done 1 cycle after acceptance, with zero tlb_re pulses.

Source files
------------

// File: rtl/tlb_op_seq_pkg.sv
// Shared constants and types for the TLB maintenance-op sequencer.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
package tlb_op_seq_pkg;

    // TLB geometry
    localparam int TLB_NUM  = 32;
    localparam int TLB_IDXW = $clog2(TLB_NUM);

    // Sequencer states
    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_WR        = 3'd1,
        ST_RD        = 3'd2,
        ST_RD_CAP    = 3'd3,
        ST_INV_SCAN  = 3'd4,
        ST_INV_DRAIN = 3'd5,
        ST_DONE      = 3'd6
    } state_t;

    // Bit positions inside the one-hot req_op code
    localparam int OP_INVTLB  = 0;
    localparam int OP_TLBWR   = 1;
    localparam int OP_TLBRD   = 2;
    localparam int OP_TLBFILL = 3;

    // invtlb operation codes; anything above INV_GA_VA is a no-op
    localparam logic [4:0] INV_ALL0       = 5'd0;
    localparam logic [4:0] INV_ALL1       = 5'd1;
    localparam logic [4:0] INV_G1         = 5'd2;
    localparam logic [4:0] INV_G0         = 5'd3;
    localparam logic [4:0] INV_G0_ASID    = 5'd4;
    localparam logic [4:0] INV_G0_ASID_VA = 5'd5;
    localparam logic [4:0] INV_GA_VA      = 5'd6;

    // invtlb operands as latched on acceptance
    typedef struct packed {
        logic [4:0]  op;
        logic [9:0]  asid;
        logic [18:0] vpn;
    } inv_args_t;

    // True when exactly one request bit is set
    function automatic logic op_is_onehot(input logic [3:0] v);
        return (v != 4'd0) && ((v & (v - 4'd1)) == 4'd0);
    endfunction

endpackage

// File: rtl/tlb_inv_match.sv
// Purpose: decides whether one TLB entry is hit by an invtlb operation.
// Latency: purely combinational, zero cycles.
// Backpressure: none; evaluated whenever read data is presented.
//
// Ports: r_e/r_g/r_asid/r_vppn describe the entry read from the TLB,
//        inv_op/inv_asid/inv_vpn are the latched invtlb operands,
//        match is high when the entry is valid and the op rule holds.
module tlb_inv_match
    import tlb_op_seq_pkg::*;
(
    input  logic        r_e,
    input  logic        r_g,
    input  logic [9:0]  r_asid,
    input  logic [18:0] r_vppn,
    input  logic [4:0]  inv_op,
    input  logic [9:0]  inv_asid,
    input  logic [18:0] inv_vpn,
    output logic        match
);

    logic asid_eq;
    logic vppn_eq;
    logic rule_hit;

    assign asid_eq = (r_asid == inv_asid);
    assign vppn_eq = (r_vppn == inv_vpn);

    always_comb begin
        rule_hit = 1'b0;
        case (inv_op)
            INV_ALL0, INV_ALL1: rule_hit = 1'b1;
            INV_G1:             rule_hit = r_g;
            INV_G0:             rule_hit = !r_g;
            INV_G0_ASID:        rule_hit = !r_g && asid_eq;
            INV_G0_ASID_VA:     rule_hit = !r_g && asid_eq && vppn_eq;
            INV_GA_VA:          rule_hit = (r_g || asid_eq) && vppn_eq;
            default:            rule_hit = 1'b0;
        endcase
    end

    // Invalid entries are never cleared, whatever the rule says
    assign match = r_e && rule_hit;

endmodule

// File: rtl/tlb_op_seq.sv
// Purpose: sequences tlbwr/tlbfill/tlbrd/invtlb onto the TLB read/write/clear ports.
// Latency: tlbwr/tlbfill 2, tlbrd 3, invtlb TLBNUM+2, no-op 1 cycle (accept to done).
// Backpressure: req_ready only in IDLE; requests in other states wait un-sampled.
//
// Ports: req_valid/req_ready/req_op + inv_* + csr_tlbidx form the request side;
//        tlb_we/tlb_w_index, tlb_re/tlb_r_index (+ r_* data one cycle later) and
//        tlb_clr/tlb_clr_index drive the TLB; rd_capture, done, busy report status.
module tlb_op_seq
    import tlb_op_seq_pkg::*;
#(
    parameter  int TLBNUM = TLB_NUM,
    localparam int IDXW   = $clog2(TLBNUM)
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            req_valid,
    output logic            req_ready,
    input  logic [3:0]      req_op,
    input  logic [4:0]      inv_op,
    input  logic [9:0]      inv_asid,
    input  logic [18:0]     inv_vpn,
    input  logic [IDXW-1:0] csr_tlbidx,
    output logic            tlb_we,
    output logic [IDXW-1:0] tlb_w_index,
    output logic            tlb_re,
    output logic [IDXW-1:0] tlb_r_index,
    input  logic            r_e,
    input  logic            r_g,
    input  logic [9:0]      r_asid,
    input  logic [18:0]     r_vppn,
    output logic            tlb_clr,
    output logic [IDXW-1:0] tlb_clr_index,
    output logic            rd_capture,
    output logic            done,
    output logic            busy
);

    localparam logic [IDXW-1:0] LAST_IDX = IDXW'(TLBNUM - 1);

    state_t          state;
    inv_args_t       inv_q;
    logic [IDXW-1:0] fill_cnt;
    logic [IDXW-1:0] scan_idx;
    // Compare stage of the invtlb scan: entry cmp_idx's data is on r_* now
    logic            cmp_vld;
    logic [IDXW-1:0] cmp_idx;
    logic            hit;

    // Free-running fill pointer; tlbfill picks whatever value it holds on acceptance
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            fill_cnt <= '0;
        end else if (fill_cnt == LAST_IDX) begin
            fill_cnt <= '0;
        end else begin
            fill_cnt <= fill_cnt + IDXW'(1);
        end
    end

    // Control FSM. Every strobe is registered together with the state it
    // belongs to, so outputs are glitch-free and all-zero under reset.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state       <= ST_IDLE;
            inv_q       <= '0;
            scan_idx    <= '0;
            cmp_vld     <= 1'b0;
            cmp_idx     <= '0;
            req_ready   <= 1'b0;
            busy        <= 1'b0;
            done        <= 1'b0;
            tlb_we      <= 1'b0;
            tlb_w_index <= '0;
            tlb_re      <= 1'b0;
            tlb_r_index <= '0;
            rd_capture  <= 1'b0;
        end else begin
            // Strobes default low; each state re-asserts what the next cycle needs
            tlb_we     <= 1'b0;
            tlb_re     <= 1'b0;
            rd_capture <= 1'b0;
            done       <= 1'b0;
            req_ready  <= 1'b0;
            busy       <= 1'b1;

            // A read issued during INV_SCAN is compared one cycle later
            cmp_vld <= (state == ST_INV_SCAN);
            cmp_idx <= scan_idx;

            case (state)
                ST_IDLE: begin
                    if (req_valid && req_ready) begin
                        inv_q    <= '{op: inv_op, asid: inv_asid, vpn: inv_vpn};
                        scan_idx <= '0;
                        if (!op_is_onehot(req_op)) begin
                            state <= ST_DONE;
                            done  <= 1'b1;
                        end else if (req_op[OP_TLBWR] || req_op[OP_TLBFILL]) begin
                            state       <= ST_WR;
                            tlb_we      <= 1'b1;
                            tlb_w_index <= req_op[OP_TLBFILL] ? fill_cnt : csr_tlbidx;
                        end else if (req_op[OP_TLBRD]) begin
                            state       <= ST_RD;
                            tlb_re      <= 1'b1;
                            tlb_r_index <= csr_tlbidx;
                        end else if (inv_op <= INV_GA_VA) begin
                            state       <= ST_INV_SCAN;
                            tlb_re      <= 1'b1;
                            tlb_r_index <= '0;
                        end else begin
                            // Undefined invtlb op: complete without touching the TLB
                            state <= ST_DONE;
                            done  <= 1'b1;
                        end
                    end else begin
                        // Also covers the first cycle after reset, when req_ready is still low
                        req_ready <= 1'b1;
                        busy      <= 1'b0;
                    end
                end

                ST_WR: begin
                    state <= ST_DONE;
                    done  <= 1'b1;
                end

                ST_RD: begin
                    state      <= ST_RD_CAP;
                    rd_capture <= 1'b1;
                end

                ST_RD_CAP: begin
                    state <= ST_DONE;
                    done  <= 1'b1;
                end

                ST_INV_SCAN: begin
                    if (scan_idx == LAST_IDX) begin
                        state <= ST_INV_DRAIN;
                    end else begin
                        scan_idx    <= scan_idx + IDXW'(1);
                        tlb_re      <= 1'b1;
                        tlb_r_index <= scan_idx + IDXW'(1);
                    end
                end

                ST_INV_DRAIN: begin
                    // Last entry is compared in this cycle via cmp_vld
                    state    <= ST_DONE;
                    done     <= 1'b1;
                    scan_idx <= '0;
                end

                ST_DONE: begin
                    state     <= ST_IDLE;
                    req_ready <= 1'b1;
                    busy      <= 1'b0;
                end

                default: begin
                    state     <= ST_IDLE;
                    req_ready <= 1'b1;
                    busy      <= 1'b0;
                end
            endcase
        end
    end

    tlb_inv_match u_match (
        .r_e      (r_e),
        .r_g      (r_g),
        .r_asid   (r_asid),
        .r_vppn   (r_vppn),
        .inv_op   (inv_q.op),
        .inv_asid (inv_q.asid),
        .inv_vpn  (inv_q.vpn),
        .match    (hit)
    );

    // Clear is issued in the compare cycle itself, gated by a registered
    // qualifier so it drops the moment reset asserts.
    assign tlb_clr       = cmp_vld && hit;
    assign tlb_clr_index = cmp_idx;

    // Write and clear come from disjoint states and must never overlap
    a_we_clr_excl: assert property (@(posedge clk) disable iff (!reset)
        !(tlb_we && tlb_clr));

    // Reads only in the two states that issue them
    a_re_states: assert property (@(posedge clk) disable iff (!reset)
        tlb_re |-> (state == ST_RD || state == ST_INV_SCAN));

    // done is a single-cycle pulse
    a_done_pulse: assert property (@(posedge clk) disable iff (!reset)
        done |=> !done);

endmodule

// File: tb/tb_tlb_op_seq.sv
module tb_tlb_op_seq;
    import tlb_op_seq_pkg::*;

    localparam int N = 32;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        req_valid, req_ready;
    logic [3:0]  req_op;
    logic [4:0]  inv_op;
    logic [9:0]  inv_asid;
    logic [18:0] inv_vpn;
    logic [4:0]  csr_tlbidx;
    logic        tlb_we, tlb_re, tlb_clr, rd_capture, done, busy;
    logic [4:0]  tlb_w_index, tlb_r_index, tlb_clr_index;
    logic        r_e, r_g;
    logic [9:0]  r_asid;
    logic [18:0] r_vppn;

    always #5 clk = ~clk;

    tlb_op_seq #(.TLBNUM(N)) dut (
        .clk(clk), .reset(reset),
        .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op),
        .inv_op(inv_op), .inv_asid(inv_asid), .inv_vpn(inv_vpn),
        .csr_tlbidx(csr_tlbidx),
        .tlb_we(tlb_we), .tlb_w_index(tlb_w_index),
        .tlb_re(tlb_re), .tlb_r_index(tlb_r_index),
        .r_e(r_e), .r_g(r_g), .r_asid(r_asid), .r_vppn(r_vppn),
        .tlb_clr(tlb_clr), .tlb_clr_index(tlb_clr_index),
        .rd_capture(rd_capture), .done(done), .busy(busy)
    );

    int errors = 0;
    int checks = 0;
    int since_rst = 0;

    // TLB contents served on the read port
    bit          mem_e[N];
    bit          mem_g[N];
    logic [9:0]  mem_asid[N];
    logic [18:0] mem_vppn[N];
    bit          re_q = 1'b0;
    logic [4:0]  ri_q = '0;

    // Events are encoded as cycle*64 + index, cycle counted from acceptance
    int exp_lat;
    int exp_we[$], exp_re[$], exp_clr[$], exp_cap[$];
    int got_we[$], got_re[$], got_clr[$], got_cap[$];
    int obs_lat, obs_we_idx;

    typedef struct {
        logic [3:0] op;
        logic [4:0] iop;
        logic [4:0] idx;
        int         lat;
        int         we_idx;
        int         re_n;
        int         cap_n;
    } vec_t;
    vec_t vt[11];

    task automatic check(input string name, input logic [31:0] act, input int exp);
        checks++;
        if (act !== 32'(exp)) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d", name, $signed(act), exp);
        end
    endtask

    // One clock: sample point is 1 after the edge, read data follows a read by one cycle
    task automatic tick();
        @(posedge clk);
        #1;
        since_rst++;
        if (re_q) begin
            r_e    = mem_e[ri_q];
            r_g    = mem_g[ri_q];
            r_asid = mem_asid[ri_q];
            r_vppn = mem_vppn[ri_q];
        end else begin
            r_e    = 1'($urandom);
            r_g    = 1'($urandom);
            r_asid = 10'($urandom);
            r_vppn = 19'($urandom);
        end
        re_q = tlb_re;
        ri_q = tlb_r_index;
        #1;
    endtask

    function automatic bit inv_hit(input int i, input int iop, input logic [9:0] asid,
                                   input logic [18:0] vpn);
        bit g, a, v;
        g = mem_g[i];
        a = (mem_asid[i] == asid);
        v = (mem_vppn[i] == vpn);
        if (!mem_e[i]) return 1'b0;
        case (iop)
            0, 1:    return 1'b1;
            2:       return g;
            3:       return !g;
            4:       return !g && a;
            5:       return !g && a && v;
            6:       return (g || a) && v;
            default: return 1'b0;
        endcase
    endfunction

    // Expected port activity for one operation, straight from the operation rules
    task automatic model(input logic [3:0] op, input logic [4:0] iop, input logic [9:0] asid,
                         input logic [18:0] vpn, input logic [4:0] idx, input int fillv);
        exp_we.delete(); exp_re.delete(); exp_clr.delete(); exp_cap.delete();
        if (!$onehot(op)) begin
            exp_lat = 1;
        end else if (op[OP_TLBWR] || op[OP_TLBFILL]) begin
            exp_lat = 2;
            exp_we.push_back(64 + (op[OP_TLBFILL] ? fillv : int'(idx)));
        end else if (op[OP_TLBRD]) begin
            exp_lat = 3;
            exp_re.push_back(64 + int'(idx));
            exp_cap.push_back(2 * 64);
        end else if (iop > 5'd6) begin
            exp_lat = 1;
        end else begin
            exp_lat = N + 2;
            for (int i = 0; i < N; i++) begin
                exp_re.push_back((i + 1) * 64 + i);
                if (inv_hit(i, int'(iop), asid, vpn)) exp_clr.push_back((i + 2) * 64 + i);
            end
        end
    endtask

    task automatic cmp_events(input string name, input int kind);
        int g[$];
        int e[$];
        case (kind)
            0:       begin g = got_we;  e = exp_we;  end
            1:       begin g = got_re;  e = exp_re;  end
            2:       begin g = got_clr; e = exp_clr; end
            default: begin g = got_cap; e = exp_cap; end
        endcase
        check($sformatf("%s_count", name), g.size(), e.size());
        if (g.size() == e.size()) begin
            foreach (g[i]) begin
                check($sformatf("%s_cycle", name), g[i] / 64, e[i] / 64);
                check($sformatf("%s_index", name), g[i] % 64, e[i] % 64);
            end
        end
    endtask

    // Issue one request and check it against the model. With hold set, a
    // second tlbwr (index 12) is left pending on the request port throughout.
    task automatic do_op(input logic [3:0] op, input logic [4:0] iop, input logic [9:0] asid,
                         input logic [18:0] vpn, input logic [4:0] idx, input bit hold,
                         input string tag);
        int w;
        int bad_hs;
        w = 0;
        while (!req_ready && w < 50) begin
            tick();
            w++;
        end
        check($sformatf("%s_ready_before", tag), req_ready, 1);
        model(op, iop, asid, vpn, idx, since_rst % N);
        req_valid = 1'b1; req_op = op; inv_op = iop; inv_asid = asid; inv_vpn = vpn;
        csr_tlbidx = idx;
        tick();
        if (hold) begin
            req_op = 4'b0010; csr_tlbidx = 5'd12;
        end else begin
            req_valid = 1'b0;
            req_op = 4'($urandom); inv_op = 5'($urandom); inv_asid = 10'($urandom);
            inv_vpn = 19'($urandom); csr_tlbidx = 5'($urandom);
        end
        got_we.delete(); got_re.delete(); got_clr.delete(); got_cap.delete();
        obs_lat = -1;
        bad_hs = 0;
        for (int t = 1; t <= 60; t++) begin
            if (tlb_we)     got_we.push_back(t * 64 + int'(tlb_w_index));
            if (tlb_re)     got_re.push_back(t * 64 + int'(tlb_r_index));
            if (tlb_clr)    got_clr.push_back(t * 64 + int'(tlb_clr_index));
            if (rd_capture) got_cap.push_back(t * 64);
            if (!busy || req_ready) bad_hs++;
            if (done) begin
                obs_lat = t;
                break;
            end
            tick();
        end
        obs_we_idx = (got_we.size() == 1) ? got_we[0] % 64 : -1;
        check($sformatf("%s_latency", tag), obs_lat, exp_lat);
        cmp_events($sformatf("%s_we", tag), 0);
        cmp_events($sformatf("%s_re", tag), 1);
        cmp_events($sformatf("%s_clr", tag), 2);
        cmp_events($sformatf("%s_cap", tag), 3);
        check($sformatf("%s_busy_not_ready", tag), bad_hs, 0);
        tick();
        check($sformatf("%s_done_one_cycle", tag), done, 0);
        check($sformatf("%s_ready_after", tag), req_ready, 1);
        check($sformatf("%s_idle_after", tag), busy, 0);
    endtask

    task automatic do_reset();
        req_valid = 1'b0;
        reset = 1'b0;
        re_q = 1'b0;
        repeat (2) tick();
        @(negedge clk);
        reset = 1'b1;
        since_rst = 0;
    endtask

    task automatic rand_mem();
        for (int i = 0; i < N; i++) begin
            mem_e[i]    = ($urandom_range(0, 3) != 0);
            mem_g[i]    = 1'($urandom);
            mem_asid[i] = 10'($urandom_range(0, 3));
            mem_vppn[i] = ($urandom_range(0, 1) != 0) ? 19'h01234 : 19'h00055;
        end
    endtask

    task automatic fill_mem(input bit e);
        for (int i = 0; i < N; i++) begin
            mem_e[i] = e; mem_g[i] = 1'b0; mem_asid[i] = '0; mem_vppn[i] = '0;
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        int seen;
        logic [3:0]  rop;
        logic [4:0]  riop;
        int          sel;

        // {op, inv_op, index, latency, written index (-1 none), reads, captures}
        vt[0]  = '{4'b0010, 5'd0,  5'd5,  2,  5, 0,  0};
        vt[1]  = '{4'b0010, 5'd3,  5'd31, 2, 31, 0,  0};
        vt[2]  = '{4'b0100, 5'd0,  5'd9,  3, -1, 1,  1};
        vt[3]  = '{4'b0100, 5'd6,  5'd0,  3, -1, 1,  1};
        vt[4]  = '{4'b0001, 5'd9,  5'd4,  1, -1, 0,  0};
        vt[5]  = '{4'b0001, 5'd7,  5'd4,  1, -1, 0,  0};
        vt[6]  = '{4'b0000, 5'd0,  5'd1,  1, -1, 0,  0};
        vt[7]  = '{4'b0110, 5'd0,  5'd1,  1, -1, 0,  0};
        vt[8]  = '{4'b1111, 5'd0,  5'd1,  1, -1, 0,  0};
        vt[9]  = '{4'b0001, 5'd2,  5'd0, 34, -1, 32, 0};
        vt[10] = '{4'b0001, 5'd31, 5'd0,  1, -1, 0,  0};

        req_valid = 1'b0; req_op = '0; inv_op = '0; inv_asid = '0; inv_vpn = '0;
        csr_tlbidx = '0; r_e = 1'b0; r_g = 1'b0; r_asid = '0; r_vppn = '0;
        fill_mem(1'b0);

        // Reset state, with a request already waiting
        reset = 1'b0;
        req_valid = 1'b1; req_op = 4'b0010; csr_tlbidx = 5'd7;
        repeat (3) tick();
        check("rst_req_ready", req_ready, 0);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_tlb_we", tlb_we, 0);
        check("rst_tlb_re", tlb_re, 0);
        check("rst_tlb_clr", tlb_clr, 0);
        check("rst_rd_capture", rd_capture, 0);
        check("rst_w_index", tlb_w_index, 0);
        check("rst_r_index", tlb_r_index, 0);
        check("rst_clr_index", tlb_clr_index, 0);
        req_valid = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        since_rst = 0;
        tick();
        check("rel_req_ready", req_ready, 1);
        check("rel_busy", busy, 0);
        check("rel_no_we", tlb_we, 0);

        // Table-driven vectors
        for (int v = 0; v < 11; v++) begin
            rand_mem();
            do_op(vt[v].op, vt[v].iop, 10'd1, 19'h01234, vt[v].idx, 1'b0,
                  $sformatf("vec%0d", v));
            check($sformatf("vec%0d_tbl_lat", v), obs_lat, vt[v].lat);
            check($sformatf("vec%0d_tbl_we_idx", v), obs_we_idx, vt[v].we_idx);
            check($sformatf("vec%0d_tbl_re_n", v), got_re.size(), vt[v].re_n);
            check($sformatf("vec%0d_tbl_cap_n", v), got_cap.size(), vt[v].cap_n);
        end

        // invtlb op 5: entry 7 matches, global entry 9 does not
        fill_mem(1'b0);
        mem_e[7] = 1'b1; mem_g[7] = 1'b0; mem_asid[7] = 10'h3; mem_vppn[7] = 19'h01234;
        mem_e[9] = 1'b1; mem_g[9] = 1'b1; mem_asid[9] = 10'h3; mem_vppn[9] = 19'h01234;
        do_op(4'b0001, 5'd5, 10'h3, 19'h01234, 5'd0, 1'b0, "inv5");
        check("inv5_clr_n", got_clr.size(), 1);
        if (got_clr.size() == 1) check("inv5_clr_idx", got_clr[0] % 64, 7);
        check("inv5_lat", obs_lat, 34);

        // invtlb op 0 with every entry valid
        fill_mem(1'b1);
        do_op(4'b0001, 5'd0, 10'h0, 19'h0, 5'd0, 1'b0, "inv0");
        check("inv0_clr_n", got_clr.size(), 32);
        if (got_clr.size() == 32) check("inv0_last_idx", got_clr[31] % 64, 31);

        // tlbfill 3 and 35 cycles after reset release
        do_reset();
        repeat (3) tick();
        do_op(4'b1000, 5'd0, 10'h0, 19'h0, 5'd0, 1'b0, "fill3");
        check("fill3_idx", obs_we_idx, 3);
        do_reset();
        repeat (35) tick();
        do_op(4'b1000, 5'd0, 10'h0, 19'h0, 5'd0, 1'b0, "fill35");
        check("fill35_idx", obs_we_idx, 3);

        // Second request held on the port for the whole invtlb scan
        rand_mem();
        do_op(4'b0001, 5'd3, 10'h0, 19'h0, 5'd0, 1'b1, "hold");
        tick();
        check("hold_second_we", tlb_we, 1);
        check("hold_second_idx", tlb_w_index, 12);
        req_valid = 1'b0;
        tick();
        check("hold_second_done", done, 1);
        tick();

        // Reset while reading entry 10 of an invtlb scan
        fill_mem(1'b1);
        req_valid = 1'b1; req_op = 4'b0001; inv_op = 5'd0;
        tick();
        req_valid = 1'b0;
        seen = 0;
        while (!(tlb_re && tlb_r_index == 5'd10) && seen < 50) begin
            tick();
            seen++;
        end
        check("midrst_at_idx10", tlb_r_index, 10);
        check("midrst_clr_before", tlb_clr, 1);
        reset = 1'b0;
        #1;
        check("midrst_re", tlb_re, 0);
        check("midrst_clr", tlb_clr, 0);
        check("midrst_we", tlb_we, 0);
        check("midrst_busy", busy, 0);
        re_q = 1'b0;
        seen = 0;
        repeat (4) begin
            tick();
            seen += int'(done) + int'(tlb_we) + int'(tlb_re) + int'(tlb_clr) + int'(rd_capture);
        end
        check("midrst_quiet", seen, 0);
        @(negedge clk);
        reset = 1'b1;
        since_rst = 0;
        tick();
        check("midrst_ready_after", req_ready, 1);

        // Randomized operations against the model
        for (int k = 0; k < 40; k++) begin
            rand_mem();
            sel = $urandom_range(0, 9);
            case (sel)
                0, 1:    rop = 4'b0010;
                2, 3:    rop = 4'b1000;
                4, 5:    rop = 4'b0100;
                6, 7, 8: rop = 4'b0001;
                default: rop = 4'($urandom);
            endcase
            riop = ($urandom_range(0, 7) == 0) ? 5'($urandom_range(7, 31))
                                               : 5'($urandom_range(0, 6));
            repeat ($urandom_range(0, 3)) tick();
            do_op(rop, riop, 10'($urandom_range(0, 3)),
                  ($urandom_range(0, 1) != 0) ? 19'h01234 : 19'h00055,
                  5'($urandom), 1'b0, $sformatf("rnd%0d", k));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
